icache_ctrl: RTL and testbench

ICACHE_CTRL -- requirements
Module: icache_ctrl

---
 rtl/icache_if.sv | 25 ++
 rtl/icache_ctrl.sv | 133 +++++++++++++
 tb/tb_icache_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Core fetch port and backing-memory beat port for the direct-mapped instruction cache.
// master: core + memory side; slave: the cache controller.
interface icache_if;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [15:0] miss_cnt;

    modport master (
        output fetch_req, fetch_addr, flush, mem_ready, mem_rdata,
        input  fetch_ready, fetch_valid, fetch_data, mem_req, mem_addr, miss_cnt
    );

    modport slave (
        input  fetch_req, fetch_addr, flush, mem_ready, mem_rdata,
        output fetch_ready, fetch_valid, fetch_data, mem_req, mem_addr, miss_cnt
    );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: single-cycle hits, in-order line refill
// from a beat-oriented backing memory, whole-cache flush.
module icache_ctrl #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic     clk,
    input  logic     rst,
    icache_if.slave  bus
);
    localparam int unsigned OFF_W = $clog2(WORDS);
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 32 - OFF_W - IDX_W - 2;

    typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

    state_t               state;
    logic [LINES-1:0]     valid;
    logic [TAG_W-1:0]     tags [LINES];
    logic [31:0]          data [LINES*WORDS];

    logic [TAG_W-1:0]     req_tag;
    logic [IDX_W-1:0]     req_idx;
    logic [OFF_W-1:0]     req_off;
    logic [OFF_W-1:0]     beat;
    logic                 flushed;

    logic                 fetch_valid_q;
    logic [31:0]          fetch_data_q;
    logic                 mem_req_q;
    logic [31:0]          mem_addr_q;
    logic [15:0]          miss_cnt_q;

    logic [TAG_W-1:0]     a_tag;
    logic [IDX_W-1:0]     a_idx;
    logic [OFF_W-1:0]     a_off;
    logic                 ready;
    logic                 accept;
    logic                 hit;
    logic                 last_beat;

    assign a_off     = bus.fetch_addr[OFF_W+1:2];
    assign a_idx     = bus.fetch_addr[OFF_W+IDX_W+1:OFF_W+2];
    assign a_tag     = bus.fetch_addr[31:OFF_W+IDX_W+2];
    assign ready     = (state == IDLE) & ~bus.flush;
    assign accept    = bus.fetch_req & ready;
    assign hit       = valid[a_idx] && (tags[a_idx] == a_tag);
    assign last_beat = (beat == OFF_W'(WORDS - 1));

    assign bus.fetch_ready = ready;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_data  = fetch_data_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.miss_cnt    = miss_cnt_q;

    // Data and tag storage carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (state == REFILL && bus.mem_ready) begin
            data[{req_idx, beat}] <= bus.mem_rdata;
            if (last_beat) begin
                tags[req_idx] <= req_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            valid         <= '0;
            req_tag       <= '0;
            req_idx       <= '0;
            req_off       <= '0;
            beat          <= '0;
            flushed       <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            miss_cnt_q    <= '0;
        end else begin
            fetch_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            fetch_valid_q <= 1'b1;
                            fetch_data_q  <= data[{a_idx, a_off}];
                        end else begin
                            req_tag    <= a_tag;
                            req_idx    <= a_idx;
                            req_off    <= a_off;
                            beat       <= '0;
                            flushed    <= 1'b0;
                            miss_cnt_q <= miss_cnt_q + 16'd1;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= {a_tag, a_idx, OFF_W'(0), 2'b00};
                            state      <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (bus.mem_ready) begin
                        if (last_beat) begin
                            // Respond straight from the final beat so the word appears one cycle after it.
                            mem_req_q      <= 1'b0;
                            beat           <= '0;
                            valid[req_idx] <= ~flushed;
                            fetch_valid_q  <= 1'b1;
                            fetch_data_q   <= (req_off == beat) ? bus.mem_rdata
                                                                : data[{req_idx, req_off}];
                            state          <= RESP;
                        end else begin
                            beat       <= beat + OFF_W'(1);
                            mem_addr_q <= {req_tag, req_idx, beat + OFF_W'(1), 2'b00};
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // A flush seen mid-refill keeps the incoming line from becoming valid.
            if (bus.flush) begin
                valid   <= '0;
                flushed <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// Randomised scoreboard bench for icache_ctrl with a line-level reference model
// and a backing-memory responder that inserts wait states.
module tb_icache_ctrl;
    logic clk = 1'b0;
    logic rst;
    icache_if bus ();

    icache_ctrl #(.LINES(16), .WORDS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          exp_cyc;   // -1: one cycle after the final refill beat
        logic [15:0] mcnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] beat_q[$];
    bit          mval[16];
    logic [23:0] mtag[16];
    logic [15:0] mmiss;
    int          passed = 0;
    int          total  = 0;
    int unsigned cyc = 0;
    int unsigned last_ready_cyc = 0;
    int          beat_cnt = 0;
    int          fixed_wait = -1;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic fail_now(input string nm, input logic [31:0] act);
        total++;
        $display("FAIL %s: actual %h (cycle %0d)", nm, act, cyc);
    endtask

    // Backing memory contents; the 0x00400000 line holds 0xA0..0xA3.
    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a[31:4] == 28'h0040000) return 32'hA0 + {28'd0, a[3:2]};
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mval[i] = 1'b0;
    endtask

    task automatic accept_model(input logic [31:0] a);
        int          idx;
        logic [23:0] tag;
        exp_t        e;
        idx = int'((a >> 4) & 32'hF);
        tag = a[31:8];
        e.data = memval(a & 32'hFFFF_FFFC);
        if (mval[idx] && mtag[idx] == tag) begin
            e.exp_cyc = int'(cyc) + 1;
        end else begin
            mmiss     = mmiss + 16'd1;
            mval[idx] = 1'b1;
            mtag[idx] = tag;
            for (int b = 0; b < 4; b++) beat_q.push_back((a & 32'hFFFF_FFF0) + 32'(b * 4));
            e.exp_cyc = -1;
        end
        e.mcnt = mmiss;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [31:0] a);
        int n = 0;
        @(negedge clk);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        bus.flush      = 1'b0;
        #1;
        while (!bus.fetch_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.fetch_ready) begin
            fail_now("issue_timeout", a);
            bus.fetch_req = 1'b0;
        end else begin
            accept_model(a);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.fetch_req = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic flush_pulse();
        @(negedge clk);
        bus.fetch_req = 1'b0;
        bus.flush     = 1'b1;
        model_clear();
        @(negedge clk);
        bus.flush = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        bus.fetch_req = 1'b0;
        bus.flush     = 1'b0;
        #1;
        while ((!bus.fetch_ready || sb.size() != 0) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) fail_now("drain_timeout", 32'(sb.size()));
    endtask

    // Backing memory: random or fixed wait states per beat, address order and stability checks.
    initial begin
        int          wcnt = 0;
        int          cur_wait = 0;
        logic [31:0] held = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
            if (!rst && bus.mem_req) begin
                chk("ready_in_refill", 32'(bus.fetch_ready), 32'd0);
                if (wcnt >= cur_wait) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = memval(bus.mem_addr);
                    if (beat_q.size() == 0) fail_now("unexpected_beat", bus.mem_addr);
                    else chk("beat_addr", bus.mem_addr, beat_q.pop_front());
                    last_ready_cyc = cyc;
                    beat_cnt++;
                    wcnt     = 0;
                    cur_wait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
                end else begin
                    if (wcnt > 0) chk("addr_stable", bus.mem_addr, held);
                    held = bus.mem_addr;
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Response monitor: every fetch_valid pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.fetch_valid) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_valid", bus.fetch_data);
                end else begin
                    e = sb.pop_front();
                    chk("fetch_data", bus.fetch_data, e.data);
                    chk("miss_cnt", 32'(bus.miss_cnt), 32'(e.mcnt));
                    chk("latency", 32'(cyc),
                        (e.exp_cyc < 0) ? 32'(last_ready_cyc + 1) : 32'(e.exp_cyc));
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [23:0] tagpool [3];
        logic [31:0] a;
        int          b0;
        tagpool[0] = 24'h004000;
        tagpool[1] = 24'h004001;
        tagpool[2] = 24'h123456;
        mmiss          = '0;
        model_clear();
        rst            = 1'b1;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.flush      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
        chk("rst_fetch_data", bus.fetch_data, 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_miss_cnt", 32'(bus.miss_cnt), 32'd0);
        chk("rst_fetch_ready", 32'(bus.fetch_ready), 32'd1);
        rst = 1'b0;

        // Cold miss, hit in the same line, then a conflicting tag on index 0.
        issue(32'h0040_0008);
        issue(32'h0040_000C);
        wait_idle();
        issue(32'h0040_0100);
        issue(32'h0040_0000);
        wait_idle();
        chk("miss_cnt_after_conflict", 32'(bus.miss_cnt), 32'd3);

        // Slow memory: three wait cycles per beat.
        fixed_wait = 3;
        issue(32'h0040_0204);
        wait_idle();
        fixed_wait = -1;

        // Flush then refetch; flush together with a request blocks it.
        flush_pulse();
        issue(32'h0040_0008);
        wait_idle();
        @(negedge clk);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h0040_0004;
        bus.flush      = 1'b1;
        #1;
        chk("ready_under_flush", 32'(bus.fetch_ready), 32'd0);
        model_clear();
        issue(32'h0040_0004);
        wait_idle();

        // Flush while a refill is in flight leaves the line invalid.
        issue(32'h0080_0030);
        flush_pulse();
        wait_idle();
        issue(32'h0080_0034);
        wait_idle();

        // Reset after the first beat of a refill.
        fixed_wait = 3;
        b0 = beat_cnt;
        issue(32'h0040_0008);
        idle();
        for (int n = 0; n < 50 && beat_cnt == b0; n++) begin
            @(negedge clk);
            #1;
        end
        if (beat_cnt == b0) fail_now("first_beat_timeout", 32'(beat_cnt));
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("midrst_fetch_ready", 32'(bus.fetch_ready), 32'd1);
        chk("midrst_miss_cnt", 32'(bus.miss_cnt), 32'd0);
        chk("midrst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
        sb.delete();
        beat_q.delete();
        model_clear();
        mmiss = '0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        b0 = beat_cnt;
        issue(32'h0040_0008);
        wait_idle();
        chk("refill_after_rst_beats", 32'(beat_cnt - b0), 32'd4);
        fixed_wait = -1;

        // Random mix of hits, misses, conflicts and flushes.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 19))
                0:       flush_pulse();
                1:       idle();
                default: begin
                    a = {tagpool[$urandom_range(0, 2)], 4'($urandom_range(0, 5)),
                         2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
                    issue(a);
                end
            endcase
        end
        wait_idle();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("beats_drained", 32'(beat_q.size()), 32'd0);
        chk("final_miss_cnt", 32'(bus.miss_cnt), 32'(mmiss));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
